wb_adc16_lane_strobe_seq: RTL
=============================

WB_ADC16_LANE_STROBE_SEQ -- requirements
Module: wb_adc16_lane_strobe_seq

Interface
REQ-001 SHALL have parameter N_CHIPS, default 8, number of ADC16 chips.
REQ-002 SHALL have parameter N_LANES, default 8, number of lanes per chip (2..16).
REQ-003 SHALL have parameter DWELL_W, default 8, width of the dwell counter.
REQ-004 SHALL derive LSEL_W = max(1, clog2(N_LANES)).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port: clk  in  1  system clock, all logic on rising edge.
REQ-007 Port: rst  in  1  synchronous active-high reset.
REQ-008 Port: chip_sel  in  N_CHIPS  per-chip enable mask.
REQ-009 Port: lane_sel  in  LSEL_W  lane index for LEVEL and PULSE modes.
REQ-010 Port: mode  in  2  0=LEVEL, 1=PULSE, 2=SCAN, 3=reserved.
REQ-011 Port: dwell  in  DWELL_W  SCAN hold per lane, in cycles minus one.
REQ-012 Port: start  in  1  single-cycle request for PULSE/SCAN.
REQ-013 Port: busy  out  1  PULSE or SCAN sequence in progress.
REQ-014 Port: done  out  1  one-cycle completion pulse.
REQ-015 Port: cur_lane  out  LSEL_W  lane currently driven.
REQ-016 Port: onehot  out  N_CHIPS*N_LANES  bit c*N_LANES+l = chip c, lane l.

Function
REQ-017 SHALL implement states IDLE, PULSE, SCAN, FIN; all outputs registered.
REQ-018 LEVEL (IDLE, mode=0): onehot[c*N_LANES+lane_sel] = chip_sel[c], all others 0, one-cycle latency, continuous.
REQ-019 lane_sel >= N_LANES in LEVEL/PULSE SHALL drive all-zero onehot.
REQ-020 mode=3 in IDLE SHALL drive all-zero onehot; start ignored.
REQ-021 start in IDLE with mode=1 or 2 SHALL latch chip_sel, lane_sel, mode, dwell; later input changes are ignored until FIN.
REQ-022 PULSE: start sampled at edge k -> onehot for latched lane high in cycle k+1 only, busy high in k+1, done high in k+2, then IDLE.
REQ-023 SCAN: lane L (0..N_LANES-1) driven for latched chips from cycle k+1+L*(dwell+1) for dwell+1 cycles; cur_lane = L.
REQ-024 SCAN: busy high from k+1 through last lane's final cycle; done high the next cycle (FIN), onehot zero in FIN.
REQ-025 dwell=0 SHALL advance one lane per cycle; dwell=all-ones SHALL hold 2^DWELL_W cycles without overflow.
REQ-026 start while busy or in FIN SHALL be ignored, no queuing.
REQ-027 Latched chip_sel=0 SHALL still run full sequence timing with onehot all-zero.
REQ-028 After FIN, SHALL return to IDLE and resume LEVEL behaviour if mode=0 next cycle.
REQ-029 busy and done SHALL never be high in the same cycle.

Reset
REQ-030 rst SHALL force IDLE; onehot=0, busy=0, done=0, cur_lane=0, dwell counter=0 on the next edge.
REQ-031 rst mid-SCAN/PULSE SHALL abort without done pulse; start concurrent with rst ignored.

Structure
REQ-032 Mode encodings and state encoding SHALL live in shared package wb_adc16_pkg as named constants.
REQ-033 Lane-to-onehot decode SHALL be sub-module wb_adc16_lane_decode (combinational, N_CHIPS/N_LANES parameters), registered in the parent.
REQ-034 Implementation SHALL be synthesizable, no latches, parameter-generic via generate loops.

Verification
REQ-035 LEVEL: N_CHIPS=8, N_LANES=8, chip_sel=8'h05, lane_sel=3 -> onehot bits 3 and 19 high one cycle later, all else 0.
REQ-036 PULSE: chip_sel=8'h80, lane_sel=7, start at edge k -> bit 63 high only in k+1, busy k+1, done k+2.
REQ-037 SCAN: chip_sel=8'h01, dwell=2 -> bits 0..7 each high 3 cycles consecutively, busy 24 cycles, done at cycle 25.
REQ-038 Boundary: dwell=0 SCAN gives 8-cycle busy; start repeated during busy ignored; N_LANES=6 with lane_sel=6 gives zero onehot.
REQ-039 Reset: rst asserted at SCAN lane 4 -> next cycle onehot=0, busy=0, no done; new start then runs full sequence from lane 0.

Source files
------------

// File: rtl/wb_adc16_pkg.sv
// Shared encodings for the ADC16 lane strobe sequencer.
package wb_adc16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_SCAN  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_LEVEL = 2'd0;
  localparam logic [1:0] MODE_PULSE = 2'd1;
  localparam logic [1:0] MODE_SCAN  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  // Lane index width; a single-bit index is kept even for tiny lane counts.
  function automatic int lsel_width(input int n_lanes);
    int w;
    w = $clog2(n_lanes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_adc16_lane_decode.sv
// Combinational chip-mask x lane-index to one-hot strobe decode.
module wb_adc16_lane_decode
  import wb_adc16_pkg::*;
#(
  parameter int N_CHIPS = 8,
  parameter int N_LANES = 8,
  localparam int LSEL_W = lsel_width(N_LANES)
) (
  input  logic [N_CHIPS-1:0]         chip_sel_i,
  input  logic [LSEL_W-1:0]          lane_i,
  input  logic                       en_i,
  output logic [N_CHIPS*N_LANES-1:0] onehot_o
);

  // Out-of-range lane indices match no generated lane and decode to zero.
  for (genvar c = 0; c < N_CHIPS; c++) begin : g_chip
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
      assign onehot_o[c*N_LANES+l] = en_i & chip_sel_i[c] & (lane_i == LSEL_W'(l));
    end
  end

endmodule

// File: rtl/wb_adc16_lane_strobe_seq.sv
// ADC16 lane strobe sequencer: LEVEL follow, single PULSE and timed SCAN.
module wb_adc16_lane_strobe_seq
  import wb_adc16_pkg::*;
#(
  parameter int N_CHIPS = 8,
  parameter int N_LANES = 8,
  parameter int DWELL_W = 8,
  localparam int LSEL_W = lsel_width(N_LANES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CHIPS-1:0]         chip_sel,
  input  logic [LSEL_W-1:0]          lane_sel,
  input  logic [1:0]                 mode,
  input  logic [DWELL_W-1:0]         dwell,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [LSEL_W-1:0]          cur_lane,
  output logic [N_CHIPS*N_LANES-1:0] onehot
);

  state_e                     state_q;
  logic [N_CHIPS-1:0]         chips_q;
  logic [DWELL_W-1:0]         dwell_q;
  logic [DWELL_W-1:0]         cnt_q;
  logic [LSEL_W-1:0]          cur_lane_q;
  logic                       busy_q;
  logic                       done_q;
  logic [N_CHIPS*N_LANES-1:0] onehot_q;

  logic [N_CHIPS-1:0]         dec_chips_d;
  logic [LSEL_W-1:0]          dec_lane_d;
  logic                       dec_en_d;
  logic [N_CHIPS*N_LANES-1:0] dec_onehot;

  // One shared decoder: live inputs while idle, latched chips and next lane while scanning.
  always_comb begin
    dec_chips_d = chip_sel;
    dec_lane_d  = lane_sel;
    dec_en_d    = 1'b1;
    if (state_q == ST_SCAN) begin
      dec_chips_d = chips_q;
      dec_lane_d  = cur_lane_q + 1'b1;
    end else if (mode == MODE_SCAN) begin
      dec_lane_d  = '0;
    end else if (mode == MODE_RSVD) begin
      dec_en_d    = 1'b0;
    end
  end

  wb_adc16_lane_decode #(
    .N_CHIPS (N_CHIPS),
    .N_LANES (N_LANES)
  ) u_decode (
    .chip_sel_i (dec_chips_d),
    .lane_i     (dec_lane_d),
    .en_i       (dec_en_d),
    .onehot_o   (dec_onehot)
  );

  // Sequencer FSM with all outputs registered; the latched mode is carried by the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      chips_q    <= '0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      cur_lane_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      onehot_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_FIN: begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (state_q == ST_IDLE && start && mode == MODE_PULSE) begin
            state_q    <= ST_PULSE;
            chips_q    <= chip_sel;
            dwell_q    <= dwell;
            cur_lane_q <= lane_sel;
            onehot_q   <= dec_onehot;
            busy_q     <= 1'b1;
          end else if (state_q == ST_IDLE && start && mode == MODE_SCAN) begin
            state_q    <= ST_SCAN;
            chips_q    <= chip_sel;
            dwell_q    <= dwell;
            cur_lane_q <= '0;
            onehot_q   <= dec_onehot;
            busy_q     <= 1'b1;
          end else begin
            // FIN falls through here too, so LEVEL output resumes right after done.
            state_q    <= ST_IDLE;
            onehot_q   <= (mode == MODE_LEVEL) ? dec_onehot : '0;
            cur_lane_q <= (mode == MODE_LEVEL) ? lane_sel : '0;
          end
        end
        ST_PULSE: begin
          state_q  <= ST_FIN;
          onehot_q <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        ST_SCAN: begin
          if (cnt_q == dwell_q) begin
            cnt_q <= '0;
            if (cur_lane_q == LSEL_W'(N_LANES - 1)) begin
              state_q  <= ST_FIN;
              onehot_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cur_lane_q <= cur_lane_q + 1'b1;
              onehot_q   <= dec_onehot;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cur_lane = cur_lane_q;
  assign onehot   = onehot_q;

endmodule
